// File: rtl/ecc_pmul_pkg.sv
// ecc_pmul_pkg: shared operand select codes, bank geometry and run-controller states
package ecc_pmul_pkg;
   localparam logic [2:0] SEL_K  = 3'd0;
   localparam logic [2:0] SEL_GX = 3'd1;
   localparam logic [2:0] SEL_GY = 3'd2;
   localparam logic [2:0] SEL_RX = 3'd3;
   localparam logic [2:0] SEL_RY = 3'd4;
   localparam int PMUL_WORDS   = 8;
   localparam int PMUL_WADDR_W = $clog2(PMUL_WORDS);
   typedef enum logic [1:0] {IDLE, ARM, RUN} pmul_state_e;
endpackage

// File: rtl/ecc_word_bank.sv
// ecc_word_bank: pWORDS x 32-bit operand store with byte and word write ports, registered word read
module ecc_word_bank
   import ecc_pmul_pkg::*;
#(
   parameter int pWORDS = PMUL_WORDS,
   parameter int pAW    = $clog2(pWORDS)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           byte_wr,
   input  logic [pAW+1:0] byte_addr,
   input  logic [7:0]     byte_wdata,
   output logic [7:0]     byte_rdata,
   input  logic           word_wr,
   input  logic [pAW-1:0] word_addr,
   input  logic [31:0]    word_wdata,
   input  logic [pAW-1:0] rd_addr,
   output logic [31:0]    rd_word
);
   logic [31:0]    mem [pWORDS];
   logic [pAW-1:0] byte_word;
   assign byte_word  = byte_addr[pAW+1:2];
   assign byte_rdata = mem[byte_word][{byte_addr[1:0], 3'b000} +: 8];
   // a word write covers every byte of its word, so it overrides a same-word byte write
   always_ff @(posedge clk)
      if (!rst_n) begin
         for (int i = 0; i < pWORDS; i++) mem[i] <= '0;
         rd_word <= '0;
      end else begin
         for (int i = 0; i < pWORDS; i++)
            if (word_wr && word_addr == pAW'(i)) mem[i] <= word_wdata;
            else if (byte_wr && byte_word == pAW'(i)) mem[i][{byte_addr[1:0], 3'b000} +: 8] <= byte_wdata;
         rd_word <= mem[rd_addr];
      end
endmodule

// File: rtl/ecc_pmul_operand_bank.sv
// ecc_pmul_operand_bank: P-256 multiplier operand/result store with host byte port and run controller
module ecc_pmul_operand_bank
   import ecc_pmul_pkg::*;
#(
   parameter int pWORDS       = PMUL_WORDS,
   parameter int pARM_TIMEOUT = 15
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [2:0]                 host_sel,
   input  logic [$clog2(pWORDS)+1:0]  host_byte_idx,
   input  logic                       host_wr,
   input  logic [7:0]                 host_wdata,
   input  logic                       host_rd,
   output logic [7:0]                 host_rdata,
   input  logic                       host_start,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   input  logic [$clog2(pWORDS)-1:0]  k_addr,
   input  logic [$clog2(pWORDS)-1:0]  gx_addr,
   input  logic [$clog2(pWORDS)-1:0]  gy_addr,
   output logic [31:0]                k_word,
   output logic [31:0]                gx_word,
   output logic [31:0]                gy_word,
   input  logic [$clog2(pWORDS)-1:0]  rx_addr,
   input  logic [$clog2(pWORDS)-1:0]  ry_addr,
   input  logic                       rx_wren,
   input  logic                       ry_wren,
   input  logic [31:0]                rx_word,
   input  logic [31:0]                ry_word,
   output logic                       core_ena,
   input  logic                       core_rdy
);
   localparam int TW = $clog2(pARM_TIMEOUT + 1);
   pmul_state_e state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic          done_n, err_n, ena_n, host_hit;
   logic [7:0]    bank_byte [8];
   logic [31:0]   bank_word [5];
   assign busy     = state != IDLE;
   assign host_hit = host_wr && host_sel <= SEL_RY;
   for (genvar g = 0; g < 5; g++) begin : g_bank
      localparam logic [2:0] SEL = 3'(g);
      ecc_word_bank #(.pWORDS(pWORDS)) u_bank (
         .clk       (clk),
         .rst_n     (rst_n),
         .byte_wr   (host_hit && !busy && host_sel == SEL),
         .byte_addr (host_byte_idx),
         .byte_wdata(host_wdata),
         .byte_rdata(bank_byte[g]),
         .word_wr   (SEL == SEL_RX ? rx_wren : SEL == SEL_RY ? ry_wren : 1'b0),
         .word_addr (SEL == SEL_RY ? ry_addr : rx_addr),
         .word_wdata(SEL == SEL_RY ? ry_word : rx_word),
         .rd_addr   (SEL == SEL_K ? k_addr : SEL == SEL_GX ? gx_addr : SEL == SEL_GY ? gy_addr : '0),
         .rd_word   (bank_word[g])
      );
   end
   for (genvar g = 5; g < 8; g++) begin : g_unmapped
      assign bank_byte[g] = 8'h00;
   end
   assign k_word  = bank_word[SEL_K];
   assign gx_word = bank_word[SEL_GX];
   assign gy_word = bank_word[SEL_GY];
   always_ff @(posedge clk)
      if (!rst_n) begin
         state      <= IDLE;
         timer      <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         core_ena   <= 1'b0;
         host_rdata <= 8'h00;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         done     <= done_n;
         err      <= err_n;
         core_ena <= ena_n;
         if (host_rd && !host_wr) host_rdata <= bank_byte[host_sel];
      end
   // timer counts the ARM cycles left; the last one with rdy still high aborts the run
   always_comb begin
      state_n = state;
      timer_n = timer;
      done_n  = done;
      err_n   = err || (host_hit && busy);
      ena_n   = 1'b0;
      case (state)
         IDLE:
            if (host_start) begin
               ena_n   = 1'b1;
               done_n  = 1'b0;
               err_n   = 1'b0;
               timer_n = TW'(pARM_TIMEOUT);
               state_n = ARM;
            end
         ARM:
            if (!core_rdy) state_n = RUN;
            else if (timer <= TW'(1)) begin
               timer_n = '0;
               err_n   = 1'b1;
               state_n = IDLE;
            end else timer_n = timer - TW'(1);
         RUN:
            if (core_rdy) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_ecc_pmul_operand_bank.sv
// tb_ecc_pmul_operand_bank: randomized and directed checks of the operand bank against a byte-array model
module tb_ecc_pmul_operand_bank;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  host_sel;
   logic [4:0]  host_byte_idx;
   logic        host_wr, host_rd, host_start;
   logic [7:0]  host_wdata, host_rdata;
   logic        busy, done, err, core_ena, core_rdy;
   logic [2:0]  k_addr, gx_addr, gy_addr, rx_addr, ry_addr;
   logic [31:0] k_word, gx_word, gy_word, rx_word, ry_word;
   logic        rx_wren, ry_wren;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  mdl [5][32];
   logic [7:0]  last_rd;
   always #5 clk = ~clk;
   ecc_pmul_operand_bank dut (
      .clk(clk), .rst_n(rst_n), .host_sel(host_sel), .host_byte_idx(host_byte_idx),
      .host_wr(host_wr), .host_wdata(host_wdata), .host_rd(host_rd), .host_rdata(host_rdata),
      .host_start(host_start), .busy(busy), .done(done), .err(err),
      .k_addr(k_addr), .gx_addr(gx_addr), .gy_addr(gy_addr),
      .k_word(k_word), .gx_word(gx_word), .gy_word(gy_word),
      .rx_addr(rx_addr), .ry_addr(ry_addr), .rx_wren(rx_wren), .ry_wren(ry_wren),
      .rx_word(rx_word), .ry_word(ry_word), .core_ena(core_ena), .core_rdy(core_rdy)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] mdl_word(input int b, input int a);
      return {mdl[b][4*a+3], mdl[b][4*a+2], mdl[b][4*a+1], mdl[b][4*a]};
   endfunction
   task automatic step();
      @(negedge clk);
   endtask
   task automatic idle_inputs();
      host_sel = 3'd0; host_byte_idx = 5'd0; host_wr = 1'b0; host_wdata = 8'h00;
      host_rd = 1'b0; host_start = 1'b0; core_rdy = 1'b1;
      k_addr = 3'd0; gx_addr = 3'd0; gy_addr = 3'd0; rx_addr = 3'd0; ry_addr = 3'd0;
      rx_wren = 1'b0; ry_wren = 1'b0; rx_word = 32'h0; ry_word = 32'h0;
   endtask
   task automatic mdl_clear();
      for (int b = 0; b < 5; b++) for (int i = 0; i < 32; i++) mdl[b][i] = 8'h00;
      last_rd = 8'h00;
   endtask
   task automatic hwrite(input int sel, input int idx, input logic [7:0] d);
      host_sel = 3'(sel); host_byte_idx = 5'(idx); host_wdata = d; host_wr = 1'b1;
      if (sel <= 4) mdl[sel][idx] = d;
      step();
      host_wr = 1'b0;
   endtask
   task automatic hread(input string tag, input int sel, input int idx);
      logic [7:0] exp;
      exp = (sel <= 4) ? mdl[sel][idx] : 8'h00;
      host_sel = 3'(sel); host_byte_idx = 5'(idx); host_rd = 1'b1;
      step();
      host_rd = 1'b0;
      check(tag, {24'h0, host_rdata}, {24'h0, exp});
      last_rd = exp;
   endtask
   task automatic sweep(input string tag);
      for (int s = 0; s < 5; s++) for (int i = 0; i < 32; i++) hread(tag, s, i);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   initial begin
      int cnt;
      logic [7:0] exp_rd;
      logic [31:0] exp_k, exp_gx, exp_gy;
      idle_inputs();
      mdl_clear();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      check("rst_busy", busy, 0); check("rst_done", done, 0);
      check("rst_err", err, 0); check("rst_ena", core_ena, 0);
      check("rst_rdata", host_rdata, 0); check("rst_kword", k_word, 0);
      sweep("rst_bank");
      hread("rst_unmapped", 6, 4);
      hwrite(0, 0, 8'hAB);
      hwrite(0, 3, 8'h12);
      k_addr = 3'd0; step();
      check("k_word0", k_word, 32'h120000AB);
      k_addr = 3'd1; step();
      check("k_word1", k_word, 32'h00000000);
      for (int it = 0; it < 400; it++) begin
         host_sel = 3'($urandom_range(0, 7)); host_byte_idx = 5'($urandom_range(0, 31));
         host_wdata = 8'($urandom); host_wr = ($urandom_range(0, 2) == 0);
         host_rd = 1'($urandom_range(0, 1));
         k_addr = 3'($urandom); gx_addr = 3'($urandom); gy_addr = 3'($urandom);
         rx_wren = ($urandom_range(0, 2) == 0); rx_addr = 3'($urandom); rx_word = $urandom;
         ry_wren = ($urandom_range(0, 2) == 0); ry_addr = 3'($urandom); ry_word = $urandom;
         exp_rd = (host_rd && !host_wr) ? ((host_sel <= 3'd4) ? mdl[host_sel][host_byte_idx] : 8'h00) : last_rd;
         exp_k = mdl_word(0, int'(k_addr)); exp_gx = mdl_word(1, int'(gx_addr)); exp_gy = mdl_word(2, int'(gy_addr));
         if (host_wr && host_sel <= 3'd4) mdl[host_sel][host_byte_idx] = host_wdata;
         if (rx_wren) for (int j = 0; j < 4; j++) mdl[3][4*rx_addr+j] = rx_word[8*j +: 8];
         if (ry_wren) for (int j = 0; j < 4; j++) mdl[4][4*ry_addr+j] = ry_word[8*j +: 8];
         step();
         check("rnd_rdata", {24'h0, host_rdata}, {24'h0, exp_rd});
         check("rnd_k", k_word, exp_k); check("rnd_gx", gx_word, exp_gx); check("rnd_gy", gy_word, exp_gy);
         last_rd = exp_rd;
      end
      idle_inputs();
      step();
      check("rnd_err", err, 0); check("rnd_busy", busy, 0); check("rnd_done", done, 0);
      sweep("rnd_bank");
      host_start = 1'b1; step(); host_start = 1'b0;
      check("run_ena", core_ena, 1); check("run_busy0", busy, 1);
      step();
      check("run_ena_off", core_ena, 0); check("run_busy1", busy, 1);
      core_rdy = 1'b0;
      repeat (5) begin step(); check("run_busy", busy, 1); end
      host_sel = 3'd0; host_byte_idx = 5'd0; host_wdata = 8'h55; host_wr = 1'b1;
      step(); host_wr = 1'b0;
      check("guard_err", err, 1); check("guard_busy", busy, 1);
      host_start = 1'b1; step(); host_start = 1'b0;
      check("restart_ena", core_ena, 0); check("restart_busy", busy, 1);
      rx_wren = 1'b1; rx_addr = 3'd7; rx_word = 32'hDEADBEEF;
      host_rd = 1'b1; host_sel = 3'd3; host_byte_idx = 5'd28;
      exp_rd = mdl[3][28];
      for (int j = 0; j < 4; j++) mdl[3][28+j] = rx_word[8*j +: 8];
      step();
      rx_wren = 1'b0; host_rd = 1'b0;
      check("collide_old", {24'h0, host_rdata}, {24'h0, exp_rd});
      hread("rx_idx31", 3, 31);
      check("rx_idx31_lit", {24'h0, host_rdata}, 32'hDE);
      hread("rx_idx28", 3, 28);
      check("rx_idx28_lit", {24'h0, host_rdata}, 32'hEF);
      repeat (88) begin step(); check("run_busy", busy, 1); end
      core_rdy = 1'b1;
      check("rdy_busy", busy, 1); check("rdy_done", done, 0);
      step();
      check("end_busy", busy, 0); check("end_done", done, 1); check("end_err", err, 1);
      hread("guard_k", 0, 0);
      host_start = 1'b1; step(); host_start = 1'b0;
      check("to_ena", core_ena, 1); check("to_errclr", err, 0); check("to_doneclr", done, 0);
      cnt = 0;
      for (int i = 0; i < 40 && busy; i++) begin cnt++; step(); end
      check("to_cycles", cnt, 15);
      check("to_err", err, 1); check("to_done", done, 0); check("to_busy", busy, 0);
      host_start = 1'b1; step(); host_start = 1'b0;
      step(); core_rdy = 1'b0;
      repeat (3) step();
      check("mid_busy", busy, 1); check("mid_err", err, 0);
      host_start = 1'b1; step(); host_start = 1'b0;
      check("mid_restart_ena", core_ena, 0); check("mid_restart_err", err, 0);
      k_addr = 3'd0; rst_n = 1'b0;
      step();
      check("mr_busy", busy, 0); check("mr_done", done, 0); check("mr_err", err, 0);
      check("mr_ena", core_ena, 0); check("mr_rdata", host_rdata, 0);
      check("mr_k", k_word, 0); check("mr_gx", gx_word, 0); check("mr_gy", gy_word, 0);
      rst_n = 1'b1; core_rdy = 1'b1;
      mdl_clear();
      step();
      check("mr_idle", busy, 0);
      sweep("mr_bank");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
